// File: rtl/dmem_load_unit.sv
// -----------------------------------------------------------------------------
// dmem_load_unit
//
// Read side of the memory stage. It accepts one load request at a time and
// issues a word-aligned read to DMEM, or to the peripheral bus when
// peripheral_ce is set. It then extracts the addressed byte, halfword or word,
// sign- or zero-extends it, and returns it to writeback with a one-cycle
// rd_valid_o pulse. Misaligned loads are never issued. They are answered with
// misalign_o=1 and rd_data_o=0.
//
// Optional build macro: LOAD_TIMEOUT_EN
//   When this macro is defined, a peripheral read that sees no per_ready_i for
//   PER_TIMEOUT PER_WAIT cycles is aborted. The unit then answers with
//   rd_data_o=TO_DATA and timeout_o=1. Without the macro, PER_WAIT waits
//   forever and timeout_o is tied to 0.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   req_valid_i    load request strobe (sampled only while req_ready_o=1)
//   alu_out_i      effective byte address
//   instr_opcode_i LB/LH/LW/LBU/LHU; every other opcode is ignored
//   peripheral_ce  1 = peripheral target, 0 = DMEM target
//   dmem_rdata_i   DMEM read data, valid the cycle after dmem_re_o
//   per_rdata_i    peripheral read data, valid with per_ready_i
//   per_ready_i    peripheral read complete
//   req_ready_o    unit idle, request can be accepted
//   addr_o         word address of the current/last load
//   dmem_re_o      DMEM read enable, one-cycle pulse
//   per_re_o       peripheral read enable, held until ready (or timeout)
//   rd_data_o      extended load result, held until the next response
//   rd_valid_o     one-cycle result strobe
//   misalign_o     misaligned-load flag, qualified by rd_valid_o
//   timeout_o      peripheral timeout flag, qualified by rd_valid_o
// -----------------------------------------------------------------------------
module dmem_load_unit #(
  parameter int unsigned PER_TIMEOUT = 16,
  parameter logic [31:0] TO_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [31:0] alu_out_i,
  input  logic [5:0]  instr_opcode_i,
  input  logic        peripheral_ce,
  input  logic [31:0] dmem_rdata_i,
  input  logic [31:0] per_rdata_i,
  input  logic        per_ready_i,
  output logic        req_ready_o,
  output logic [31:0] addr_o,
  output logic        dmem_re_o,
  output logic        per_re_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100010;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_CAPTURE  = 3'd2,
    S_PER_WAIT = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [5:0]  op_q, op_d;
  logic        ce_q, ce_d;
  logic [31:0] data_q, data_d;
  logic        mis_q, mis_d;

  // The control outputs are registered from the next state. This keeps them
  // glitch-free and lets reset hold all of them, req_ready_o included, at 0.
  logic        ready_q;
  logic        dmem_re_q;
  logic        per_re_q;
  logic        valid_q;

`ifdef LOAD_TIMEOUT_EN
  // The counter only has to reach PER_TIMEOUT-1.
  localparam int unsigned     CNT_W    = (PER_TIMEOUT > 1) ? $clog2(PER_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PER_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`else
  // The timeout parameters only matter when the timeout logic is built.
  // They are folded into this otherwise unused net so they stay referenced.
  logic unused_cfg;
  assign unused_cfg = ^{PER_TIMEOUT, TO_DATA};
`endif

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU: return off[0];
      OP_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  // Selects the addressed lane of the read word and extends it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [5:0]  op,
                                          input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a variable unassigned would otherwise infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    ce_d    = ce_q;
    data_d  = data_q;
    mis_d   = mis_q;
`ifdef LOAD_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && is_load(instr_opcode_i)) begin
          addr_d = alu_out_i;
          op_d   = instr_opcode_i;
          ce_d   = peripheral_ce;
          if (is_misaligned(instr_opcode_i, alu_out_i[1:0])) begin
            data_d  = '0;
            mis_d   = 1'b1;
`ifdef LOAD_TIMEOUT_EN
            to_d    = 1'b0;
`endif
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
`ifdef LOAD_TIMEOUT_EN
        cnt_d   = '0;
`endif
        // A per_ready_i seen during this cycle is deliberately ignored.
        state_d = ce_q ? S_PER_WAIT : S_CAPTURE;
      end

      S_CAPTURE: begin
        data_d  = extract(dmem_rdata_i, op_q, addr_q[1:0]);
        mis_d   = 1'b0;
`ifdef LOAD_TIMEOUT_EN
        to_d    = 1'b0;
`endif
        state_d = S_RESP;
      end

      S_PER_WAIT: begin
        // Ready is tested before the timeout, so it wins a same-cycle tie.
        if (per_ready_i) begin
          data_d  = extract(per_rdata_i, op_q, addr_q[1:0]);
          mis_d   = 1'b0;
`ifdef LOAD_TIMEOUT_EN
          to_d    = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef LOAD_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          data_d  = TO_DATA;
          mis_d   = 1'b0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      op_q      <= '0;
      ce_q      <= 1'b0;
      data_q    <= '0;
      mis_q     <= 1'b0;
      ready_q   <= 1'b0;
      dmem_re_q <= 1'b0;
      per_re_q  <= 1'b0;
      valid_q   <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      ce_q      <= ce_d;
      data_q    <= data_d;
      mis_q     <= mis_d;
      ready_q   <= (state_d == S_IDLE);
      dmem_re_q <= (state_d == S_ISSUE) && !ce_d;
      per_re_q  <= ((state_d == S_ISSUE) || (state_d == S_PER_WAIT)) && ce_d;
      valid_q   <= (state_d == S_RESP);
`ifdef LOAD_TIMEOUT_EN
      cnt_q     <= cnt_d;
      to_q      <= to_d;
`endif
    end
  end

  assign req_ready_o = ready_q;
  assign addr_o      = {addr_q[31:2], 2'b00};
  assign dmem_re_o   = dmem_re_q;
  assign per_re_o    = per_re_q;
  assign rd_data_o   = data_q;
  assign rd_valid_o  = valid_q;
  assign misalign_o  = mis_q;
`ifdef LOAD_TIMEOUT_EN
  assign timeout_o   = to_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_load_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_load_unit
//
// Self-checking bench for dmem_load_unit. Each load is driven through
// run_load, which plays the DMEM and peripheral side and records what the
// unit did. The expected behaviour comes from a behavioural model. The model
// works on byte offsets and arithmetic sign extension, and it counts cycles
// per target. It does not copy the RTL's state machine.
// -----------------------------------------------------------------------------
module tb_dmem_load_unit;

  localparam int unsigned PER_TIMEOUT = 16;
  localparam logic [31:0] TO_DATA     = 32'hDEAD_BEEF;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100010;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic [31:0] alu_out_i;
  logic [5:0]  instr_opcode_i;
  logic        peripheral_ce;
  logic [31:0] dmem_rdata_i;
  logic [31:0] per_rdata_i;
  logic        per_ready_i;
  logic        req_ready_o;
  logic [31:0] addr_o;
  logic        dmem_re_o;
  logic        per_re_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        misalign_o;
  logic        timeout_o;

  dmem_load_unit #(.PER_TIMEOUT(PER_TIMEOUT), .TO_DATA(TO_DATA)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i),
    .alu_out_i(alu_out_i), .instr_opcode_i(instr_opcode_i),
    .peripheral_ce(peripheral_ce), .dmem_rdata_i(dmem_rdata_i),
    .per_rdata_i(per_rdata_i), .per_ready_i(per_ready_i),
    .req_ready_o(req_ready_o), .addr_o(addr_o), .dmem_re_o(dmem_re_o),
    .per_re_o(per_re_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        got;        // rd_valid_o seen within the budget
    int          lat;        // cycles from acceptance to rd_valid_o
    int          n_dre;      // cycles with dmem_re_o high
    int          n_pre;      // cycles with per_re_o high
    int          n_valid;    // cycles with rd_valid_o high
    logic [31:0] data;
    logic        mis;
    logic        to;
    logic        addr_bad;   // addr_o wrong while a read enable was high
    logic        ready_bad;  // req_ready_o high while busy
    logic        post_valid; // rd_valid_o in the cycle after the response
    logic        post_ready;
    logic [31:0] post_data;
  } result_t;

  typedef struct {
    int          lat;
    int          n_dre;
    int          n_pre;
    logic [31:0] data;
    logic        mis;
    logic        to;
  } exp_t;

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] ref_extract(input logic [5:0] op,
                                              input logic [31:0] addr,
                                              input logic [31:0] word);
    logic [31:0] v;
    int unsigned off;
    off = addr % 4;
    case (op)
      OP_LB, OP_LBU: begin
        v = (word >> (8 * off)) & 32'hFF;
        if (op == OP_LB && v >= 128) v = v - 256;
      end
      OP_LH, OP_LHU: begin
        v = (word >> (8 * (off / 2) * 2)) & 32'hFFFF;
        if (op == OP_LH && v >= 32768) v = v - 65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic exp_t predict(input logic [5:0] op, input logic [31:0] addr,
                                   input logic ce, input logic [31:0] word,
                                   input int ready_at);
    exp_t e;
    int   wait_cycles;
    e.lat = 0; e.n_dre = 0; e.n_pre = 0; e.data = '0; e.mis = 1'b0; e.to = 1'b0;
    if (((op == OP_LH || op == OP_LHU) && addr % 2 != 0) ||
        (op == OP_LW && addr % 4 != 0)) begin
      e.lat = 1;
      e.mis = 1'b1;
    end else if (!ce) begin
      e.lat   = 3;
      e.n_dre = 1;
      e.data  = ref_extract(op, addr, word);
    end else begin
      // The issue cycle never completes the read, so at least one wait cycle.
      wait_cycles = (ready_at < 1) ? 1 : ready_at;
`ifdef LOAD_TIMEOUT_EN
      if (wait_cycles > int'(PER_TIMEOUT)) begin
        e.n_pre = int'(PER_TIMEOUT) + 1;
        e.lat   = e.n_pre + 1;
        e.data  = TO_DATA;
        e.to    = 1'b1;
        return e;
      end
`endif
      e.n_pre = wait_cycles + 1;
      e.lat   = e.n_pre + 1;
      e.data  = ref_extract(op, addr, word);
    end
    return e;
  endfunction

  // ------------------------------------------------------ transaction driver
  // This task is entered at a negedge with the unit idle. The bench presents
  // the request for one cycle, then observes and drives once per negedge.
  // DMEM returns `word` only in the cycle after dmem_re_o and random data
  // otherwise. The peripheral raises per_ready_i once per_re_o has been high
  // for ready_at+1 cycles.
  task automatic run_load(input logic [5:0] op, input logic [31:0] addr,
                          input logic ce, input logic [31:0] word,
                          input int ready_at, input int budget,
                          output result_t r);
    logic prev_dre;
    r.got = 1'b0; r.lat = 0; r.n_dre = 0; r.n_pre = 0; r.n_valid = 0;
    r.data = '0; r.mis = 1'b0; r.to = 1'b0; r.addr_bad = 1'b0;
    r.ready_bad = 1'b0; r.post_valid = 1'b0; r.post_ready = 1'b0;
    r.post_data = '0;
    prev_dre       = 1'b0;
    req_valid_i    = 1'b1;
    instr_opcode_i = op;
    alu_out_i      = addr;
    peripheral_ce  = ce;
    per_ready_i    = 1'b0;
    dmem_rdata_i   = $urandom;
    per_rdata_i    = $urandom;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_i);
      req_valid_i    = 1'b0;
      alu_out_i      = $urandom;
      instr_opcode_i = 6'($urandom);
      peripheral_ce  = 1'($urandom);
      if (r.got) begin
        r.post_valid = rd_valid_o;
        r.post_ready = req_ready_o;
        r.post_data  = rd_data_o;
        break;
      end
      if (dmem_re_o) r.n_dre++;
      if (per_re_o)  r.n_pre++;
      if ((dmem_re_o || per_re_o) && addr_o !== {addr[31:2], 2'b00}) r.addr_bad = 1'b1;
      if (req_ready_o) r.ready_bad = 1'b1;
      if (rd_valid_o) begin
        r.got = 1'b1; r.lat = c; r.n_valid++;
        r.data = rd_data_o; r.mis = misalign_o; r.to = timeout_o;
      end
      dmem_rdata_i = prev_dre ? word : $urandom;
      prev_dre     = dmem_re_o;
      if (per_re_o && r.n_pre >= ready_at + 1) begin
        per_ready_i = 1'b1;
        per_rdata_i = word;
      end else begin
        per_ready_i = 1'b0;
        per_rdata_i = $urandom;
      end
    end
    per_ready_i = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = 1'b0; alu_out_i = '0; instr_opcode_i = '0;
    peripheral_ce = 1'b0; dmem_rdata_i = '0; per_rdata_i = '0; per_ready_i = 1'b0;
    #2;
    n_checks++;
    if ({req_ready_o, dmem_re_o, per_re_o, rd_valid_o, misalign_o, timeout_o,
         addr_o, rd_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b re=%b/%b valid=%b addr=%h data=%h, expected all 0",
               req_ready_o, dmem_re_o, per_re_o, rd_valid_o, addr_o, rd_data_o);
    end
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_held: got %b expected 0", req_ready_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b expected 1", req_ready_o);
    end
  endtask

  task automatic test_idle_ignore();
    logic [5:0] ops [4] = '{6'b101010, 6'b000000, 6'b100011, 6'b101000};
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1; instr_opcode_i = ops[i];
      alu_out_i = $urandom & 32'hFFFF_FFFC; peripheral_ce = 1'($urandom);
      @(negedge clk_i);
      n_checks++;
      if ({req_ready_o, dmem_re_o, per_re_o, rd_valid_o} !== 4'b1000) begin
        n_fail++;
        $display("FAIL ignore_op_%b: got ready/dre/pre/valid=%b expected 1000",
                 ops[i], {req_ready_o, dmem_re_o, per_re_o, rd_valid_o});
      end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic test_dmem_loads();
    logic [5:0]  ops  [6] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LB};
    logic [31:0] adrs [6] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h100, 32'h100};
    logic [31:0] exps [6] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80F1,
                              32'h0000_7F22, 32'h80F1_7F22, 32'h0000_0022};
    result_t r;
    for (int i = 0; i < 6; i++) begin
      run_load(ops[i], adrs[i], 1'b0, 32'h80F1_7F22, 0, 20, r);
      n_checks++;
      if (!r.got || r.lat != 3) begin
        n_fail++; $display("FAIL dmem_latency_%0d: got valid=%b lat=%0d expected lat 3", i, r.got, r.lat);
      end
      n_checks++;
      if (r.data !== exps[i] || r.mis !== 1'b0 || r.to !== 1'b0) begin
        n_fail++; $display("FAIL dmem_data_%0d: got %h mis=%b to=%b expected %h", i, r.data, r.mis, r.to, exps[i]);
      end
      n_checks++;
      if (r.n_dre != 1 || r.n_pre != 0 || r.addr_bad || r.ready_bad) begin
        n_fail++;
        $display("FAIL dmem_handshake_%0d: got dre=%0d pre=%0d addr_bad=%b ready_bad=%b expected 1/0/0/0",
                 i, r.n_dre, r.n_pre, r.addr_bad, r.ready_bad);
      end
      n_checks++;
      if (r.post_valid !== 1'b0 || r.post_ready !== 1'b1 || r.post_data !== exps[i]) begin
        n_fail++;
        $display("FAIL dmem_after_resp_%0d: got valid=%b ready=%b data=%h expected 0/1/%h",
                 i, r.post_valid, r.post_ready, r.post_data, exps[i]);
      end
    end
    n_checks++;
    if (addr_o !== 32'h100) begin
      n_fail++; $display("FAIL dmem_addr_o: got %h expected 00000100", addr_o);
    end
  endtask

  task automatic test_misaligned();
    logic [5:0]  ops  [4] = '{OP_LW, OP_LH, OP_LHU, OP_LW};
    logic [31:0] adrs [4] = '{32'h102, 32'h101, 32'h103, 32'h4000_0001};
    logic        ces  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    result_t r;
    for (int i = 0; i < 4; i++) begin
      run_load(ops[i], adrs[i], ces[i], 32'hFFFF_FFFF, 0, 20, r);
      n_checks++;
      if (!r.got || r.lat != 1 || r.mis !== 1'b1 || r.data !== 32'h0) begin
        n_fail++;
        $display("FAIL misaligned_%0d: got valid=%b lat=%0d mis=%b data=%h expected lat 1 mis 1 data 0",
                 i, r.got, r.lat, r.mis, r.data);
      end
      n_checks++;
      if (r.n_dre != 0 || r.n_pre != 0) begin
        n_fail++; $display("FAIL misaligned_noread_%0d: got dre=%0d pre=%0d expected 0/0", i, r.n_dre, r.n_pre);
      end
    end
  endtask

  task automatic test_peripheral();
    result_t r;
    run_load(OP_LW, 32'h4000_0004, 1'b1, 32'h1234_5678, 5, 30, r);
    n_checks++;
    if (!r.got || r.n_pre != 6 || r.lat != 7) begin
      n_fail++; $display("FAIL per_timing: got valid=%b pre=%0d lat=%0d expected 1/6/7", r.got, r.n_pre, r.lat);
    end
    n_checks++;
    if (r.data !== 32'h1234_5678 || r.n_dre != 0 || r.addr_bad || r.to !== 1'b0) begin
      n_fail++;
      $display("FAIL per_data: got %h dre=%0d addr_bad=%b to=%b expected 12345678/0/0/0",
               r.data, r.n_dre, r.addr_bad, r.to);
    end
    // Ready already high during the issue cycle must not complete the read.
    run_load(OP_LB, 32'h4000_0007, 1'b1, 32'h9A00_0000, 0, 30, r);
    n_checks++;
    if (!r.got || r.n_pre != 2 || r.data !== 32'hFFFF_FF9A) begin
      n_fail++; $display("FAIL per_early_ready: got pre=%0d data=%h expected 2/ffffff9a", r.n_pre, r.data);
    end
  endtask

  task automatic test_timeout();
    result_t r;
`ifdef LOAD_TIMEOUT_EN
    run_load(OP_LW, 32'h4000_0010, 1'b1, 32'h0BAD_F00D, 1000, 40, r);
    n_checks++;
    if (!r.got || r.to !== 1'b1 || r.data !== TO_DATA || r.n_pre != int'(PER_TIMEOUT) + 1) begin
      n_fail++;
      $display("FAIL timeout_abort: got valid=%b to=%b data=%h pre=%0d expected 1/1/%h/%0d",
               r.got, r.to, r.data, r.n_pre, TO_DATA, PER_TIMEOUT + 1);
    end
    n_checks++;
    if (r.post_ready !== 1'b1 || r.post_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: got ready=%b valid=%b expected 1/0", r.post_ready, r.post_valid);
    end
    // Ready arriving in the same cycle the count expires wins.
    run_load(OP_LW, 32'h4000_0014, 1'b1, 32'h0BAD_F00D, int'(PER_TIMEOUT), 40, r);
    n_checks++;
    if (!r.got || r.to !== 1'b0 || r.data !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL timeout_tie: got to=%b data=%h expected 0/0badf00d", r.to, r.data);
    end
`else
    run_load(OP_LW, 32'h4000_0010, 1'b1, 32'h0BAD_F00D, 1000, 50, r);
    n_checks++;
    if (r.got || per_re_o !== 1'b1 || req_ready_o !== 1'b0 || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_wait: got valid=%b per_re=%b ready=%b to=%b expected 0/1/0/0",
               r.got, per_re_o, req_ready_o, timeout_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
`endif
  endtask

  task automatic test_reset_mid();
    result_t r;
    run_load(OP_LW, 32'h4000_0020, 1'b1, 32'h5555_AAAA, 1000, 5, r);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({req_ready_o, dmem_re_o, per_re_o, rd_valid_o, misalign_o, timeout_o,
         addr_o, rd_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got ready=%b per_re=%b valid=%b addr=%h data=%h expected all 0",
               req_ready_o, per_re_o, rd_valid_o, addr_o, rd_data_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    per_ready_i = 1'b1;
    per_rdata_i = 32'h5555_AAAA;
    r.n_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (rd_valid_o) r.n_valid++;
    end
    per_ready_i = 1'b0;
    n_checks++;
    if (r.n_valid != 0 || req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_abort: got valids=%0d ready=%b expected 0/1", r.n_valid, req_ready_o);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [5:0] ops [5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    result_t r;
    exp_t    e;
    logic [5:0]  op;
    logic [31:0] addr, word;
    logic        ce;
    int          ready_at;
    for (int i = 0; i < 60; i++) begin
      op       = ops[$urandom_range(0, 4)];
      addr     = $urandom;
      ce       = 1'($urandom);
      word     = $urandom;
      ready_at = $urandom_range(0, 8);
      e = predict(op, addr, ce, word, ready_at);
      run_load(op, addr, ce, word, ready_at, 40, r);
      n_checks++;
      if (!r.got || r.lat != e.lat || r.n_valid != 1 || r.post_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_timing_%0d: op=%b addr=%h ce=%b got lat=%0d valids=%0d post=%b expected lat=%0d",
                 i, op, addr, ce, r.lat, r.n_valid, r.post_valid, e.lat);
      end
      n_checks++;
      if (r.data !== e.data || r.mis !== e.mis || r.to !== e.to) begin
        n_fail++;
        $display("FAIL rand_result_%0d: op=%b addr=%h word=%h got %h mis=%b to=%b expected %h mis=%b to=%b",
                 i, op, addr, word, r.data, r.mis, r.to, e.data, e.mis, e.to);
      end
      n_checks++;
      if (r.n_dre != e.n_dre || r.n_pre != e.n_pre || r.addr_bad || r.ready_bad) begin
        n_fail++;
        $display("FAIL rand_bus_%0d: got dre=%0d pre=%0d addr_bad=%b ready_bad=%b expected dre=%0d pre=%0d",
                 i, r.n_dre, r.n_pre, r.addr_bad, r.ready_bad, e.n_dre, e.n_pre);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_dmem_loads();
    test_misaligned();
    test_peripheral();
    test_timeout();
    test_reset_mid();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_load_unit.md
Name: dmem_load_unit

Overview:
- Read-side counterpart of the store path in the memory stage.
- Accepts a load request and issues a word-aligned read to DMEM or to the peripheral bus, selected by peripheral_ce.
- Extracts the addressed byte, halfword or word, then sign- or zero-extends it.
- Returns the result to writeback with a one-cycle valid pulse. Flags misaligned loads instead of issuing them.

Parameters:
- PER_TIMEOUT, 16: peripheral wait cycles before abort. Used only with LOAD_TIMEOUT_EN.
- TO_DATA, 32'hDEAD_BEEF: rd_data_o value returned on peripheral timeout.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  load request strobe from the memory stage.
- alu_out_i  input  32  effective address.
- instr_opcode_i  input  6  opcodes: LB 6'b100000, LH 6'b100001, LW 6'b100010, LBU 6'b100100, LHU 6'b100101.
- peripheral_ce  input  1  1 = peripheral target, 0 = DMEM target.
- dmem_rdata_i  input  32  DMEM read data, valid one cycle after dmem_re_o.
- per_rdata_i  input  32  peripheral read data, valid when per_ready_i is high.
- per_ready_i  input  1  peripheral read complete.
- req_ready_o  output  1  unit is idle and can accept a request.
- addr_o  output  32  word address {addr[31:2], 2'b00}.
- dmem_re_o  output  1  DMEM read enable, one-cycle pulse.
- per_re_o  output  1  peripheral read enable, held until ready.
- rd_data_o  output  32  extended load result.
- rd_valid_o  output  1  result strobe, one cycle.
- misalign_o  output  1  misaligned-load flag, qualified by rd_valid_o.
- timeout_o  output  1  peripheral timeout flag, qualified by rd_valid_o. Tied 0 without LOAD_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_i=1):
  - State goes to IDLE.
  - All outputs and internal registers are 0, including req_ready_o.
  - Reset asserted mid-transaction aborts it; no rd_valid_o is produced.
- State machine: IDLE, ISSUE, CAPTURE, PER_WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i with a load opcode: latch address, opcode and peripheral_ce.
  - Non-load opcodes are ignored; stay in IDLE.
  - Misaligned request (LH/LHU with addr[0]=1, or LW with addr[1:0]!=00): no read is issued. Go to RESP with rd_data=0 and misalign=1.
  - Otherwise go to ISSUE.
- ISSUE:
  - addr_o is driven.
  - DMEM target: dmem_re_o=1 for this cycle, next state CAPTURE.
  - Peripheral target: per_re_o=1, next state PER_WAIT.
- CAPTURE: sample dmem_rdata_i, extract into the result register, go to RESP.
- PER_WAIT:
  - per_re_o and addr_o are held.
  - When per_ready_i=1: sample per_rdata_i, extract, go to RESP.
  - A per_ready_i already high in the ISSUE cycle is ignored; sampling starts in PER_WAIT.
- RESP: rd_valid_o=1 for one cycle, then go to IDLE. No request is accepted during RESP.
- rd_data_o, misalign_o and timeout_o hold their values until the next RESP.
- Latency: a DMEM load accepted in cycle T produces rd_valid_o in cycle T+3. A peripheral load produces rd_valid_o in the cycle after per_ready_i is sampled. A misaligned load produces it in cycle T+1.
- Extraction, with off = addr[1:0]:
  - LB: sign-extend word[8*off+7:8*off].
  - LBU: zero-extend the same byte.
  - LH: sign-extend word[16*off[1]+15:16*off[1]].
  - LHU: zero-extend the same halfword.
  - LW: whole word.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- When defined: a counter runs in PER_WAIT.
  - If per_ready_i has not arrived after PER_TIMEOUT cycles, per_re_o drops and the FSM goes to RESP with rd_data_o=TO_DATA and timeout_o=1.
  - The counter clears on entry to PER_WAIT.
  - If per_ready_i arrives in the same cycle the count expires, the ready wins.
- When undefined: PER_WAIT waits indefinitely, no counter logic is built, and timeout_o is tied to 0.

Test Plan:
- DMEM load: dmem_rdata_i=32'h80F1_7F22, LB at addr 0x103 -> rd_data_o=32'hFFFF_FF80 in cycle T+3; LBU at 0x101 -> 32'h0000_007F (byte 1 = 8'h7F).
- DMEM halfword/word: same word, LH at 0x102 -> 32'hFFFF_80F1; LHU at 0x100 -> 32'h0000_7F22; LW at 0x100 -> 32'h80F1_7F22; addr_o=0x100 in every case.
- Misaligned loads: LW at 0x102 and LH at 0x101 -> no dmem_re_o, rd_valid_o at T+1 with misalign_o=1 and rd_data_o=0.
- Peripheral load: peripheral_ce=1, LW at 0x4000_0004, per_ready_i raised after 5 cycles with 32'h1234_5678 -> per_re_o held 6 cycles, rd_valid_o with 32'h1234_5678, dmem_re_o never high.
- Peripheral timeout (LOAD_TIMEOUT_EN, PER_TIMEOUT=16): per_ready_i held 0 -> rd_valid_o with timeout_o=1 and rd_data_o=32'hDEAD_BEEF, FSM back to IDLE. With the macro undefined, the unit stays in PER_WAIT.
- Reset and idle behaviour: rst_i pulsed during PER_WAIT -> outputs clear immediately and no rd_valid_o appears. req_valid_i with SW opcode 6'b101010 -> ignored, req_ready_o stays 1.
